// File: rtl/branch_issue_queue.sv
// Branch/jump reservation station: compacting age-ordered queue that captures
// CDB results and issues the oldest ready op to the single branch unit each cycle.
module branch_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       disp_valid_i,
    output logic                       disp_ready_o,
    input  logic [31:0]                disp_pc_i,
    input  logic [31:0]                disp_imm_i,
    input  logic                       disp_is_branch_i,
    input  logic                       disp_is_jump_i,
    input  logic                       disp_pred_taken_i,
    input  logic [TAG_W-1:0]           disp_rob_tag_i,
    input  logic                       disp_rs1_rdy_i,
    input  logic                       disp_rs2_rdy_i,
    input  logic [TAG_W-1:0]           disp_rs1_tag_i,
    input  logic [TAG_W-1:0]           disp_rs2_tag_i,
    input  logic [31:0]                disp_rs1_val_i,
    input  logic [31:0]                disp_rs2_val_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [31:0]                cdb_data_i,
    output logic                       iss_valid_o,
    output logic [31:0]                iss_pc_o,
    output logic [31:0]                iss_imm_o,
    output logic [31:0]                iss_rs1_val_o,
    output logic [31:0]                iss_rs2_val_o,
    output logic                       iss_is_branch_o,
    output logic                       iss_is_jump_o,
    output logic                       iss_pred_taken_o,
    output logic [TAG_W-1:0]           iss_rob_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic             is_branch;
        logic             is_jump;
        logic             pred_taken;
        logic [TAG_W-1:0] rob_tag;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_val;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_val;
    } entry_t;

    // Capture a broadcast result into any still-waiting operand of a live entry.
    function automatic entry_t wake(input entry_t e, input logic v,
                                    input logic [TAG_W-1:0] t, input logic [31:0] d);
        entry_t r;
        logic   h1;
        logic   h2;
        r         = e;
        h1        = v && e.valid && !e.rs1_rdy && (e.rs1_tag == t);
        h2        = v && e.valid && !e.rs2_rdy && (e.rs2_tag == t);
        r.rs1_rdy = e.rs1_rdy | h1;
        r.rs1_val = h1 ? d : e.rs1_val;
        r.rs2_rdy = e.rs2_rdy | h2;
        r.rs2_val = h2 ? d : e.rs2_val;
        return r;
    endfunction

    entry_t             r_q   [DEPTH];
    entry_t             w_sh  [DEPTH];
    entry_t             w_nxt [DEPTH];
    entry_t             w_new;
    entry_t             w_sel;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   w_rdy_vec;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_issue;
    logic               w_disp_acc;
    logic [CNT_W-1:0]   w_wr_idx;

    // Oldest-ready select; the descending scan lets the lowest index win.
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy_vec[i] = r_q[i].valid && r_q[i].rs1_rdy && r_q[i].rs2_rdy;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_sel_idx = w_rdy_vec[i] ? IDX_W'(i) : w_sel_idx;
        end
        w_sel_found = |w_rdy_vec;
    end

    assign w_sel        = r_q[w_sel_idx];
    assign iss_valid_o  = w_sel_found && !flush_i;
    assign w_issue      = iss_valid_o;
    assign disp_ready_o = (r_count < CNT_W'(DEPTH));
    assign w_disp_acc   = disp_valid_i && disp_ready_o && !flush_i;
    assign w_wr_idx     = r_count - CNT_W'(w_issue);
    assign count_o      = r_count;

    assign iss_pc_o         = w_sel.pc;
    assign iss_imm_o        = w_sel.imm;
    assign iss_rs1_val_o    = w_sel.rs1_val;
    assign iss_rs2_val_o    = w_sel.rs2_val;
    assign iss_is_branch_o  = w_sel.is_branch;
    assign iss_is_jump_o    = w_sel.is_jump;
    assign iss_pred_taken_o = w_sel.pred_taken;
    assign iss_rob_tag_o    = w_sel.rob_tag;

    // Remove the issued entry by shifting everything above it down one slot.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_sh[i] = (w_issue && (IDX_W'(i) >= w_sel_idx)) ? r_q[i + 1] : r_q[i];
        end
        w_sh[DEPTH-1] = w_issue ? entry_t'('0) : r_q[DEPTH-1];
    end

    // Build the incoming entry from the dispatch port.
    always_comb begin
        w_new            = '0;
        w_new.valid      = 1'b1;
        w_new.pc         = disp_pc_i;
        w_new.imm        = disp_imm_i;
        w_new.is_branch  = disp_is_branch_i;
        w_new.is_jump    = disp_is_jump_i;
        w_new.pred_taken = disp_pred_taken_i;
        w_new.rob_tag    = disp_rob_tag_i;
        w_new.rs1_rdy    = disp_rs1_rdy_i;
        w_new.rs1_tag    = disp_rs1_tag_i;
        w_new.rs1_val    = disp_rs1_val_i;
        w_new.rs2_rdy    = disp_rs2_rdy_i;
        w_new.rs2_tag    = disp_rs2_tag_i;
        w_new.rs2_val    = disp_rs2_val_i;
    end

    // Wake the compacted entries, then drop the new op into the first free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = (w_disp_acc && (CNT_W'(i) == w_wr_idx))
                     ? wake(w_new, cdb_valid_i, cdb_tag_i, cdb_data_i)
                     : wake(w_sh[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
        end
    end

    // Queue storage and occupancy; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nxt[i];
            end
            r_count <= r_count - CNT_W'(w_issue) + CNT_W'(w_disp_acc);
        end
    end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue with an age-ordered queue model checked every cycle.
module tb_branch_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic             clk;
    logic             rst;
    logic             flush_i;
    logic             disp_valid_i;
    logic             disp_ready_o;
    logic [31:0]      disp_pc_i;
    logic [31:0]      disp_imm_i;
    logic             disp_is_branch_i;
    logic             disp_is_jump_i;
    logic             disp_pred_taken_i;
    logic [TAG_W-1:0] disp_rob_tag_i;
    logic             disp_rs1_rdy_i;
    logic             disp_rs2_rdy_i;
    logic [TAG_W-1:0] disp_rs1_tag_i;
    logic [TAG_W-1:0] disp_rs2_tag_i;
    logic [31:0]      disp_rs1_val_i;
    logic [31:0]      disp_rs2_val_i;
    logic             cdb_valid_i;
    logic [TAG_W-1:0] cdb_tag_i;
    logic [31:0]      cdb_data_i;
    logic             iss_valid_o;
    logic [31:0]      iss_pc_o;
    logic [31:0]      iss_imm_o;
    logic [31:0]      iss_rs1_val_o;
    logic [31:0]      iss_rs2_val_o;
    logic             iss_is_branch_o;
    logic             iss_is_jump_o;
    logic             iss_pred_taken_o;
    logic [TAG_W-1:0] iss_rob_tag_o;
    logic [2:0]       count_o;

    branch_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_pc_i(disp_pc_i), .disp_imm_i(disp_imm_i),
        .disp_is_branch_i(disp_is_branch_i), .disp_is_jump_i(disp_is_jump_i),
        .disp_pred_taken_i(disp_pred_taken_i), .disp_rob_tag_i(disp_rob_tag_i),
        .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs2_rdy_i(disp_rs2_rdy_i),
        .disp_rs1_tag_i(disp_rs1_tag_i), .disp_rs2_tag_i(disp_rs2_tag_i),
        .disp_rs1_val_i(disp_rs1_val_i), .disp_rs2_val_i(disp_rs2_val_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
        .iss_valid_o(iss_valid_o), .iss_pc_o(iss_pc_o), .iss_imm_o(iss_imm_o),
        .iss_rs1_val_o(iss_rs1_val_o), .iss_rs2_val_o(iss_rs2_val_o),
        .iss_is_branch_o(iss_is_branch_o), .iss_is_jump_o(iss_is_jump_o),
        .iss_pred_taken_o(iss_pred_taken_o), .iss_rob_tag_o(iss_rob_tag_o),
        .count_o(count_o)
    );

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic             br;
        logic             jmp;
        logic             pt;
        logic [TAG_W-1:0] tag;
        logic             r1;
        logic [TAG_W-1:0] t1;
        logic [31:0]      v1;
        logic             r2;
        logic [TAG_W-1:0] t2;
        logic [31:0]      v2;
    } op_t;

    op_t mq[$];
    int  total;
    int  bad;
    bit  chk_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int find_rdy();
        int r;
        r = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (r < 0 && mq[i].r1 && mq[i].r2) r = i;
        end
        return r;
    endfunction

    task automatic model_compare();
        int   s;
        logic ev;
        s  = find_rdy();
        ev = (s >= 0) && !flush_i;
        chk("iss_valid", 32'(iss_valid_o), 32'(ev));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("disp_ready", 32'(disp_ready_o), 32'(mq.size() < DEPTH));
        if (ev) begin
            chk("iss_pc", iss_pc_o, mq[s].pc);
            chk("iss_imm", iss_imm_o, mq[s].imm);
            chk("iss_rs1", iss_rs1_val_o, mq[s].v1);
            chk("iss_rs2", iss_rs2_val_o, mq[s].v2);
            chk("iss_br", 32'(iss_is_branch_o), 32'(mq[s].br));
            chk("iss_jmp", 32'(iss_is_jump_o), 32'(mq[s].jmp));
            chk("iss_pt", 32'(iss_pred_taken_o), 32'(mq[s].pt));
            chk("iss_tag", 32'(iss_rob_tag_o), 32'(mq[s].tag));
        end
    endtask

    // Advance the model across the coming edge using this cycle's inputs.
    task automatic model_step();
        int  s;
        int  n;
        op_t o;
        if (rst || flush_i) begin
            mq.delete();
        end else begin
            s = find_rdy();
            n = mq.size();
            if (s >= 0) mq.delete(s);
            if (cdb_valid_i) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].r1 && mq[i].t1 == cdb_tag_i) begin
                        mq[i].r1 = 1'b1;
                        mq[i].v1 = cdb_data_i;
                    end
                    if (!mq[i].r2 && mq[i].t2 == cdb_tag_i) begin
                        mq[i].r2 = 1'b1;
                        mq[i].v2 = cdb_data_i;
                    end
                end
            end
            if (disp_valid_i && n < DEPTH) begin
                o.pc  = disp_pc_i;         o.imm = disp_imm_i;
                o.br  = disp_is_branch_i;  o.jmp = disp_is_jump_i;
                o.pt  = disp_pred_taken_i; o.tag = disp_rob_tag_i;
                o.r1  = disp_rs1_rdy_i;    o.t1  = disp_rs1_tag_i; o.v1 = disp_rs1_val_i;
                o.r2  = disp_rs2_rdy_i;    o.t2  = disp_rs2_tag_i; o.v2 = disp_rs2_val_i;
                if (!o.r1 && cdb_valid_i && o.t1 == cdb_tag_i) begin o.r1 = 1'b1; o.v1 = cdb_data_i; end
                if (!o.r2 && cdb_valid_i && o.t2 == cdb_tag_i) begin o.r2 = 1'b1; o.v2 = cdb_data_i; end
                mq.push_back(o);
            end
        end
    endtask

    // Inputs only change just after a rising edge, so mid-cycle is a safe sample point.
    always @(negedge clk) begin
        if (chk_en) model_compare();
        model_step();
    end

    task automatic idle();
        disp_valid_i = 1'b0; disp_pc_i = 32'h0; disp_imm_i = 32'h0;
        disp_is_branch_i = 1'b0; disp_is_jump_i = 1'b0; disp_pred_taken_i = 1'b0;
        disp_rob_tag_i = '0; disp_rs1_rdy_i = 1'b0; disp_rs2_rdy_i = 1'b0;
        disp_rs1_tag_i = '0; disp_rs2_tag_i = '0;
        disp_rs1_val_i = 32'h0; disp_rs2_val_i = 32'h0;
        cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_data_i = 32'h0;
        flush_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic disp(input logic [31:0] pc, input logic br, input logic jmp, input logic pt,
                        input logic [TAG_W-1:0] tag,
                        input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
        disp_valid_i = 1'b1; disp_pc_i = pc; disp_imm_i = pc + 32'h40;
        disp_is_branch_i = br; disp_is_jump_i = jmp; disp_pred_taken_i = pt;
        disp_rob_tag_i = tag;
        disp_rs1_rdy_i = r1; disp_rs1_tag_i = t1; disp_rs1_val_i = v1;
        disp_rs2_rdy_i = r2; disp_rs2_tag_i = t2; disp_rs2_val_i = v2;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        cdb_valid_i = 1'b1; cdb_tag_i = tag; cdb_data_i = data;
    endtask

    initial begin
        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b1;
        idle();
        tick(); tick();
        rst = 1'b0; chk_en = 1'b1;
        @(negedge clk);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_iss_valid", 32'(iss_valid_o), 32'd0);
        chk("rst_ready", 32'(disp_ready_o), 32'd1);

        // Ready BNE issues the cycle after dispatch.
        tick();
        disp(32'h100, 1'b1, 1'b0, 1'b0, 6'd5, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
        tick();
        @(negedge clk);
        chk("bne_valid", 32'(iss_valid_o), 32'd1);
        chk("bne_tag", 32'(iss_rob_tag_o), 32'd5);
        chk("bne_rs1", iss_rs1_val_o, 32'd1);
        chk("bne_rs2", iss_rs2_val_o, 32'd2);
        chk("bne_count1", 32'(count_o), 32'd1);
        tick();
        @(negedge clk);
        chk("bne_count0", 32'(count_o), 32'd0);

        // Younger ready op bypasses an older waiting one; issue+dispatch share a cycle.
        tick();
        disp(32'h200, 1'b1, 1'b0, 1'b1, 6'd1, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd3);
        tick();
        disp(32'h204, 1'b1, 1'b0, 1'b0, 6'd2, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 32'd8);
        @(negedge clk);
        chk("a_waits", 32'(iss_valid_o), 32'd0);
        tick();
        cdb(6'd9, 32'h40);
        disp(32'h208, 1'b1, 1'b0, 1'b0, 6'd4, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
        @(negedge clk);
        chk("b_first", 32'(iss_rob_tag_o), 32'd2);
        tick();
        @(negedge clk);
        chk("a_tag", 32'(iss_rob_tag_o), 32'd1);
        chk("a_rs1", iss_rs1_val_o, 32'h40);
        tick();
        @(negedge clk);
        chk("c_tag", 32'(iss_rob_tag_o), 32'd4);

        // Same-cycle CDB capture on dispatch of a jump.
        tick();
        disp(32'h300, 1'b0, 1'b1, 1'b1, 6'd3, 1'b1, 6'd0, 32'h11, 1'b0, 6'd7, 32'd0);
        cdb(6'd7, 32'hAB);
        tick();
        @(negedge clk);
        chk("cap_valid", 32'(iss_valid_o), 32'd1);
        chk("cap_rs2", iss_rs2_val_o, 32'hAB);
        chk("cap_jmp", 32'(iss_is_jump_o), 32'd1);

        // Fill the queue, issue from the middle, then check order after shifting.
        tick();
        disp(32'h400, 1'b1, 1'b0, 1'b0, 6'd10, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        disp(32'h404, 1'b1, 1'b0, 1'b0, 6'd11, 1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'd1);
        tick();
        disp(32'h408, 1'b1, 1'b0, 1'b0, 6'd12, 1'b0, 6'd22, 32'd0, 1'b1, 6'd0, 32'd2);
        tick();
        disp(32'h40C, 1'b1, 1'b0, 1'b0, 6'd13, 1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'd3);
        tick();
        cdb(6'd22, 32'h22);
        @(negedge clk);
        chk("full_ready", 32'(disp_ready_o), 32'd0);
        chk("full_count", 32'(count_o), 32'd4);
        tick();
        disp(32'h410, 1'b1, 1'b0, 1'b0, 6'd14, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
        @(negedge clk);
        chk("mid_tag", 32'(iss_rob_tag_o), 32'd12);
        chk("mid_rs1", iss_rs1_val_o, 32'h22);
        chk("full_issue_ready", 32'(disp_ready_o), 32'd0);
        tick();
        cdb(6'd21, 32'h21);
        @(negedge clk);
        chk("reopen_ready", 32'(disp_ready_o), 32'd1);
        chk("reopen_count", 32'(count_o), 32'd3);
        tick();
        @(negedge clk);
        chk("order_11", 32'(iss_rob_tag_o), 32'd11);
        tick();
        cdb(6'd20, 32'h20);
        @(negedge clk);
        chk("order_13", 32'(iss_rob_tag_o), 32'd13);
        tick();
        @(negedge clk);
        chk("order_10", 32'(iss_rob_tag_o), 32'd10);
        tick();
        @(negedge clk);
        chk("drain_count", 32'(count_o), 32'd0);

        // Flush with a ready entry and a colliding dispatch.
        tick();
        disp(32'h500, 1'b1, 1'b0, 1'b0, 6'd30, 1'b0, 6'd40, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        disp(32'h504, 1'b1, 1'b0, 1'b0, 6'd31, 1'b0, 6'd41, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        disp(32'h508, 1'b1, 1'b0, 1'b0, 6'd32, 1'b0, 6'd42, 32'd0, 1'b1, 6'd0, 32'd0);
        cdb(6'd41, 32'h41);
        tick();
        flush_i = 1'b1;
        disp(32'h50C, 1'b1, 1'b0, 1'b0, 6'd33, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0);
        @(negedge clk);
        chk("flush_iss", 32'(iss_valid_o), 32'd0);
        chk("flush_count_pre", 32'(count_o), 32'd3);
        tick();
        cdb(6'd40, 32'h40);
        @(negedge clk);
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_iss_after", 32'(iss_valid_o), 32'd0);
        tick();
        cdb(6'd42, 32'h42);
        tick();
        @(negedge clk);
        chk("flush_dropped", 32'(iss_valid_o), 32'd0);

        // Reset mid-operation with two ready entries.
        tick();
        disp(32'h600, 1'b1, 1'b0, 1'b0, 6'd20, 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        disp(32'h604, 1'b1, 1'b0, 1'b0, 6'd21, 1'b0, 6'd50, 32'd0, 1'b1, 6'd0, 32'd0);
        tick();
        cdb(6'd50, 32'h50);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_iss", 32'(iss_valid_o), 32'd0);
        chk("rst2_count", 32'(count_o), 32'd0);
        chk("rst2_ready", 32'(disp_ready_o), 32'd1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_issue_queue.md
# branch_issue_queue

Reservation station and issue scheduler for the single branch/jump functional unit. It accepts dispatched branch and jump ops, captures their operands from the common data bus (CDB), and issues the oldest op whose operands are ready, at most one per cycle. It sits between dispatch/rename and the branch unit. It clears itself on a pipeline flush.

## Interface
- DEPTH, 4: number of queue entries (≥2)
- TAG_W, 6: ROB tag width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries (mispredict recovery)
- disp_valid_i  in  1  dispatch request
- disp_ready_o  out  1  queue can accept a dispatch this cycle
- disp_pc_i, disp_imm_i  in  32 each  PC and pre-offset immediate
- disp_is_branch_i, disp_is_jump_i, disp_pred_taken_i  in  1 each  op type and fetch prediction
- disp_rob_tag_i  in  TAG_W  destination ROB tag
- disp_rs1_rdy_i, disp_rs2_rdy_i  in  1 each  operand already available
- disp_rs1_tag_i, disp_rs2_tag_i  in  TAG_W each  producer ROB tag if not ready
- disp_rs1_val_i, disp_rs2_val_i  in  32 each  operand value if ready
- cdb_valid_i  in  1  result broadcast valid
- cdb_tag_i  in  TAG_W  broadcast producer tag
- cdb_data_i  in  32  broadcast value
- iss_valid_o  out  1  op presented to branch unit this cycle
- iss_pc_o, iss_imm_o, iss_rs1_val_o, iss_rs2_val_o  out  32 each
- iss_is_branch_o, iss_is_jump_o, iss_pred_taken_o  out  1 each
- iss_rob_tag_o  out  TAG_W
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is a compacting queue. Entry 0 is the oldest. Valid entries are contiguous from index 0.
- Each entry holds: valid, pc, imm, type bits, pred_taken, rob_tag, and per operand {rdy, tag, val}.
- Dispatch is accepted when disp_valid_i && disp_ready_o && !flush_i.
  - disp_ready_o = (count < DEPTH). It does not account for a same-cycle issue.
  - The new entry is written at index (count − issued_this_cycle).
- Wakeup: every valid entry with an operand where !rdy && tag == cdb_tag_i && cdb_valid_i sets rdy=1 and val=cdb_data_i.
  - A dispatching op whose operand is not ready and whose tag matches the same-cycle CDB captures cdb_data_i and enters with rdy=1.
- Select: the lowest-index valid entry with both rdy bits set, evaluated from registered state only. A wakeup in cycle N makes the entry eligible in cycle N+1.
- Issue:
  - iss_valid_o = select found && !flush_i.
  - iss_* fields are driven combinationally from the selected entry.
  - The branch unit has no backpressure, so an issue always completes. The issued entry is removed at the clock edge, and younger entries shift down one index while preserving order.
  - A non-head entry may issue before older non-ready entries (out of order among branches).
- Simultaneous events in one cycle: issue, wakeup and dispatch all apply. Compaction applies first, then wakeup to the shifted entries, then the dispatch write.
- Flush: all valid bits clear at the edge and the dispatch that cycle is dropped. Flush has priority over everything. It is legal at any time, including when full or mid-wakeup.
- count_o next = count − issue + dispatch_accepted (0 on flush or rst).

## Timing
- Reset: all entry valid bits 0; count_o=0; iss_valid_o=0; disp_ready_o=1. Other iss_* values are don't-care while iss_valid_o=0 but must not be X (drive entry 0 fields or zero).
- Dispatch-to-issue latency, both operands ready at dispatch: dispatch accepted at edge N, iss_valid_o high in cycle N+1.
- CDB-to-issue latency: broadcast in cycle N, iss_valid_o high in cycle N+1.
- Throughput: 1 issue per cycle.
- Full queue: disp_ready_o=0 in that cycle even if an issue occurs. The slot reopens the following cycle.
- flush_i asserted in cycle N: iss_valid_o=0 in cycle N, queue empty in cycle N+1.

## Test plan
- Reset, then dispatch a BNE (rob_tag 5, both operands ready, rs1=1, rs2=2) at edge 0 -> iss_valid_o=1 in cycle 1 with rob_tag 5, vals 1/2; count returns to 0 after edge 1.
- Dispatch A (tag 1, rs1 waiting on tag 9), then B (tag 2, ready) -> B issues first. CDB tag 9, data 0x40 -> A issues the next cycle with rs1_val=0x40.
- Dispatch with rs2 waiting on tag 7 while cdb_valid/tag 7/data 0xAB is present the same cycle -> entry captured ready; issues next cycle with rs2_val=0xAB.
- Fill with 4 waiting ops -> disp_ready_o=0. Wake entry 2 -> it issues, entries 3 shift to index 2, disp_ready_o=1 the following cycle, and the order of the remaining ops is preserved on later wakeups.
- Queue holds 3 entries, one ready, and flush_i=1 with a simultaneous dispatch -> iss_valid_o=0 that cycle; count_o=0 next cycle; the dropped dispatch never issues.
- Assert rst mid-operation with 2 ready entries -> next cycle iss_valid_o=0, count_o=0, disp_ready_o=1.
